// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO target: oversamples MDC/MDIO on clk_50, decodes frames for PHY_ADDR,
// serves a small PHY register file and drives MDIO during read turnaround/data.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] ID1          = 16'h0022,
    parameter logic [15:0] ID2          = 16'h1556,
    parameter logic [15:0] BMSR_VAL     = 16'h786D
) (
    input  logic        clk_50,
    input  logic        rstn,
    input  logic        i_mdc,
    input  logic        i_mdio,
    output logic        o_mdio,
    output logic        oe_mdio,
    output logic [15:0] o_bmcr,
    output logic        o_frame_done,
    output logic        o_frame_err
);
    localparam logic [15:0] BMCR_RST = 16'h3100;
    localparam logic [15:0] ANAR_RST = 16'h01E1;
    localparam logic [5:0]  PRE_MAX  = 6'(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
    } state_t;

    logic [1:0] mdc_sync, mdio_sync;
    logic       mdc_q, rise_q, bit_q;

    // Edge detect and sampled bit are registered together so they stay aligned.
    always_ff @(posedge clk_50 or negedge rstn) begin
        if (!rstn) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
            mdc_q     <= 1'b0;
            rise_q    <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[0], i_mdc};
            mdio_sync <= {mdio_sync[0], i_mdio};
            mdc_q     <= mdc_sync[1];
            rise_q    <= mdc_sync[1] & ~mdc_q;
            bit_q     <= mdio_sync[1];
        end
    end

    state_t      state, state_n;
    logic [5:0]  pre_cnt, pre_cnt_n;
    logic [4:0]  bit_cnt, bit_cnt_n, phyad, phyad_n, regad, regad_n;
    logic [15:0] shreg, shreg_n;
    logic        is_read, is_read_n, ta1, ta1_n;
    logic        mdio_n, oe_n, done_n, err_n;
    logic        wr_en;
    logic [15:0] wr_data, rd_data;
    logic [4:0]  rd_addr;

    logic [15:0]       bmcr, anar;
    logic [7:0][15:0]  scratch;

    assign o_bmcr  = bmcr;
    assign rd_addr = {regad[3:0], bit_q};
    assign wr_data = {shreg[14:0], bit_q};

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            5'd0:    rd_data = bmcr;
            5'd1:    rd_data = BMSR_VAL;
            5'd2:    rd_data = ID1;
            5'd3:    rd_data = ID2;
            5'd4:    rd_data = anar;
            default: if (rd_addr[4:3] == 2'b10) rd_data = scratch[rd_addr[2:0]];
        endcase
    end

    always_ff @(posedge clk_50 or negedge rstn) begin
        if (!rstn) begin
            state        <= S_PRE;
            pre_cnt      <= '0;
            bit_cnt      <= '0;
            phyad        <= '0;
            regad        <= '0;
            shreg        <= '0;
            is_read      <= 1'b0;
            ta1          <= 1'b0;
            o_mdio       <= 1'b0;
            oe_mdio      <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state        <= state_n;
            pre_cnt      <= pre_cnt_n;
            bit_cnt      <= bit_cnt_n;
            phyad        <= phyad_n;
            regad        <= regad_n;
            shreg        <= shreg_n;
            is_read      <= is_read_n;
            ta1          <= ta1_n;
            o_mdio       <= mdio_n;
            oe_mdio      <= oe_n;
            o_frame_done <= done_n;
            o_frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        pre_cnt_n = pre_cnt;
        bit_cnt_n = bit_cnt;
        phyad_n   = phyad;
        regad_n   = regad;
        shreg_n   = shreg;
        is_read_n = is_read;
        ta1_n     = ta1;
        mdio_n    = o_mdio;
        oe_n      = oe_mdio;
        done_n    = 1'b0;
        err_n     = 1'b0;
        wr_en     = 1'b0;
        if (rise_q) begin
            case (state)
                S_PRE: begin
                    if (bit_q) begin
                        if (pre_cnt != PRE_MAX) pre_cnt_n = pre_cnt + 6'd1;
                    end else if (pre_cnt == PRE_MAX) begin
                        state_n   = S_ST;
                        pre_cnt_n = '0;
                    end else begin
                        pre_cnt_n = '0;
                    end
                end
                S_ST: begin
                    bit_cnt_n = '0;
                    if (bit_q) state_n = S_OP;
                    else begin
                        err_n   = 1'b1;
                        state_n = S_PRE;
                    end
                end
                S_OP: begin
                    shreg_n = {shreg[14:0], bit_q};
                    if (bit_cnt == 5'd1) begin
                        bit_cnt_n = '0;
                        case ({shreg[0], bit_q})
                            2'b10:   begin is_read_n = 1'b1; state_n = S_PHYAD; end
                            2'b01:   begin is_read_n = 1'b0; state_n = S_PHYAD; end
                            default: begin err_n = 1'b1; state_n = S_PRE; end
                        endcase
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
                S_PHYAD: begin
                    phyad_n   = {phyad[3:0], bit_q};
                    bit_cnt_n = (bit_cnt == 5'd4) ? 5'd0 : bit_cnt + 5'd1;
                    if (bit_cnt == 5'd4) state_n = S_REGAD;
                end
                S_REGAD: begin
                    regad_n = rd_addr;
                    if (bit_cnt == 5'd4) begin
                        // Foreign address: swallow TA + 16 data bits silently.
                        if (phyad != PHY_ADDR) begin
                            state_n   = S_SKIP;
                            bit_cnt_n = 5'd17;
                        end else begin
                            shreg_n   = rd_data;
                            state_n   = S_TA;
                            bit_cnt_n = '0;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt == 5'd0) begin
                        bit_cnt_n = 5'd1;
                        ta1_n     = bit_q;
                        if (is_read) begin
                            oe_n   = 1'b1;
                            mdio_n = 1'b0;
                        end
                    end else begin
                        bit_cnt_n = '0;
                        if (is_read) begin
                            mdio_n  = shreg[15];
                            shreg_n = {shreg[14:0], 1'b0};
                            state_n = S_DATA;
                        end else if (ta1 && !bit_q) begin
                            state_n = S_DATA;
                        end else begin
                            err_n     = 1'b1;
                            state_n   = S_SKIP;
                            bit_cnt_n = 5'd15;
                        end
                    end
                end
                S_DATA: begin
                    if (is_read) begin
                        if (bit_cnt == 5'd15) begin
                            oe_n    = 1'b0;
                            mdio_n  = 1'b0;
                            done_n  = 1'b1;
                            state_n = S_PRE;
                        end else begin
                            mdio_n    = shreg[15];
                            shreg_n   = {shreg[14:0], 1'b0};
                            bit_cnt_n = bit_cnt + 5'd1;
                        end
                    end else begin
                        shreg_n = wr_data;
                        if (bit_cnt == 5'd15) begin
                            wr_en   = 1'b1;
                            done_n  = 1'b1;
                            state_n = S_PRE;
                        end else begin
                            bit_cnt_n = bit_cnt + 5'd1;
                        end
                    end
                end
                S_SKIP: begin
                    if (bit_cnt == 5'd0) state_n = S_PRE;
                    else bit_cnt_n = bit_cnt - 5'd1;
                end
                default: state_n = S_PRE;
            endcase
        end
    end

    // BMCR bit 15 is self-clearing: it resets every RW register and discards the rest of the write.
    always_ff @(posedge clk_50 or negedge rstn) begin
        if (!rstn) begin
            bmcr    <= BMCR_RST;
            anar    <= ANAR_RST;
            scratch <= '0;
        end else if (wr_en) begin
            case (regad)
                5'd0: begin
                    if (wr_data[15]) begin
                        bmcr    <= BMCR_RST;
                        anar    <= ANAR_RST;
                        scratch <= '0;
                    end else begin
                        bmcr <= {1'b0, wr_data[14:0]};
                    end
                end
                5'd4:    anar <= wr_data;
                default: if (regad[4:3] == 2'b10) scratch[regad[2:0]] <= wr_data;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: bit-bangs MDC/MDIO frames as a master and scoreboards read data.
module tb_mdio_phy_responder;
    logic        clk_50 = 1'b0;
    logic        rstn   = 1'b0;
    logic        i_mdc  = 1'b0;
    logic        m_en   = 1'b1;
    logic        m_val  = 1'b1;
    logic        bus;
    logic        o_mdio, oe_mdio, o_frame_done, o_frame_err;
    logic [15:0] o_bmcr;

    int n_tests = 0, n_fail = 0;
    int done_cnt = 0, err_cnt = 0, oe_cnt = 0, wide_cnt = 0;
    logic prev_done = 1'b0, prev_err = 1'b0;
    logic [15:0] exp_q[$];

    // Open-drain style bus with pull-up: responder wins while enabled, else master or pull-up.
    assign bus = oe_mdio ? o_mdio : (m_en ? m_val : 1'b1);

    mdio_phy_responder dut (
        .clk_50(clk_50), .rstn(rstn), .i_mdc(i_mdc), .i_mdio(bus),
        .o_mdio(o_mdio), .oe_mdio(oe_mdio), .o_bmcr(o_bmcr),
        .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
    );

    always #10 clk_50 = ~clk_50;

    always @(negedge clk_50) begin
        if (o_frame_done) done_cnt++;
        if (o_frame_err) err_cnt++;
        if (oe_mdio) oe_cnt++;
        if ((o_frame_done && prev_done) || (o_frame_err && prev_err)) wide_cnt++;
        prev_done = o_frame_done;
        prev_err  = o_frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic clk_bit(input logic drv, input logic val, output logic smp);
        m_en  = drv;
        m_val = val;
        repeat (8) @(negedge clk_50);
        smp   = bus;
        i_mdc = 1'b1;
        repeat (8) @(negedge clk_50);
        i_mdc = 1'b0;
    endtask

    task automatic send(input logic v);
        logic s;
        clk_bit(1'b1, v, s);
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) send(1'b1);
    endtask

    task automatic send_hdr(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg);
        send(1'b0); send(1'b1);
        for (int i = 1; i >= 0; i--) send(op[i]);
        for (int i = 4; i >= 0; i--) send(phy[i]);
        for (int i = 4; i >= 0; i--) send(rg[i]);
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] rg,
                              output logic [15:0] got, output logic ta2);
        logic s;
        send_hdr(2'b10, phy, rg);
        clk_bit(1'b0, 1'b1, s);
        clk_bit(1'b0, 1'b1, ta2);
        for (int i = 15; i >= 0; i--) begin
            clk_bit(1'b0, 1'b1, s);
            got[i] = s;
        end
        m_en = 1'b1;
        m_val = 1'b1;
    endtask

    task automatic write_frame(input logic [4:0] rg, input logic [15:0] d, input logic [1:0] ta);
        send_hdr(2'b01, 5'd1, rg);
        send(ta[1]); send(ta[0]);
        for (int i = 15; i >= 0; i--) send(d[i]);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk_50);
        n_tests++; if (oe_mdio !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", oe_mdio); end
        n_tests++; if (o_mdio !== 1'b0) begin n_fail++; $display("FAIL reset_mdio got %b want 0", o_mdio); end
        n_tests++; if (o_bmcr !== 16'h3100) begin n_fail++; $display("FAIL reset_bmcr got %h want 3100", o_bmcr); end
        rstn = 1'b1;
        repeat (5) @(negedge clk_50);
        n_tests++; if (done_cnt !== 0 || err_cnt !== 0) begin n_fail++; $display("FAIL reset_pulses got %0d/%0d want 0/0", done_cnt, err_cnt); end
    endtask

    task automatic test_read_id();
        logic [15:0] got, e;
        logic ta2;
        int d0, o0;
        d0 = done_cnt; o0 = oe_cnt;
        preamble(32);
        exp_q.push_back(16'h0022);
        read_frame(5'd1, 5'd2, got, ta2);
        e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL read_id1 got %h want %h", got, e); end
        n_tests++; if (ta2 !== 1'b0) begin n_fail++; $display("FAIL read_ta2 got %b want 0", ta2); end
        n_tests++; if (oe_mdio !== 1'b0) begin n_fail++; $display("FAIL read_oe_release got %b want 0", oe_mdio); end
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL read_done got %0d want 1", done_cnt - d0); end
        n_tests++; if (oe_cnt - o0 !== 272) begin n_fail++; $display("FAIL read_oe_width got %0d want 272", oe_cnt - o0); end
    endtask

    task automatic test_write_read();
        logic [15:0] got, e;
        logic ta2;
        int d0;
        d0 = done_cnt;
        preamble(32);
        write_frame(5'd17, 16'hA5A5, 2'b10);
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL write_done got %0d want 1", done_cnt - d0); end
        exp_q.push_back(16'hA5A5); preamble(32); read_frame(5'd1, 5'd17, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL read_reg17 got %h want %h", got, e); end
        exp_q.push_back(16'h786D); preamble(32); read_frame(5'd1, 5'd1, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL read_bmsr got %h want %h", got, e); end
        exp_q.push_back(16'h1556); preamble(32); read_frame(5'd1, 5'd3, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL read_id2 got %h want %h", got, e); end
        preamble(32); write_frame(5'd2, 16'hFFFF, 2'b10);
        exp_q.push_back(16'h0022); preamble(32); read_frame(5'd1, 5'd2, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL ro_write_ignored got %h want %h", got, e); end
        preamble(32); write_frame(5'd9, 16'hBEEF, 2'b10);
        exp_q.push_back(16'h0000); preamble(32); read_frame(5'd1, 5'd9, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL unmapped_read got %h want %h", got, e); end
    endtask

    task automatic test_bmcr_reset();
        logic [15:0] got, e;
        logic ta2;
        preamble(32); write_frame(5'd0, 16'h4000, 2'b10);
        n_tests++; if (o_bmcr !== 16'h4000) begin n_fail++; $display("FAIL bmcr_write got %h want 4000", o_bmcr); end
        preamble(32); write_frame(5'd4, 16'h1234, 2'b10);
        preamble(32); write_frame(5'd0, 16'h8000, 2'b10);
        n_tests++; if (o_bmcr !== 16'h3100) begin n_fail++; $display("FAIL bmcr_soft_reset got %h want 3100", o_bmcr); end
        exp_q.push_back(16'h01E1); preamble(32); read_frame(5'd1, 5'd4, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL anar_after_reset got %h want %h", got, e); end
        exp_q.push_back(16'h0000); preamble(32); read_frame(5'd1, 5'd17, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL scratch_after_reset got %h want %h", got, e); end
        exp_q.push_back(16'h3100); preamble(32); read_frame(5'd1, 5'd0, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL bmcr_read got %h want %h", got, e); end
    endtask

    task automatic test_other_phy();
        logic [15:0] got, e;
        logic ta2;
        int d0, e0, o0;
        d0 = done_cnt; e0 = err_cnt; o0 = oe_cnt;
        preamble(32);
        read_frame(5'd7, 5'd2, got, ta2);
        n_tests++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL other_phy_oe got %0d want 0", oe_cnt - o0); end
        n_tests++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL other_phy_pulses got %0d/%0d want 0/0", done_cnt - d0, err_cnt - e0); end
        read_frame(5'd1, 5'd2, got, ta2);
        n_tests++; if (oe_cnt - o0 !== 0 || done_cnt - d0 !== 0) begin n_fail++; $display("FAIL no_preamble_ignored got oe %0d done %0d want 0/0", oe_cnt - o0, done_cnt - d0); end
        exp_q.push_back(16'h0022); preamble(32); read_frame(5'd1, 5'd2, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL read_after_skip got %h want %h", got, e); end
    endtask

    task automatic test_bad_frames();
        logic [15:0] got, e;
        logic ta2;
        int d0, e0, o0;
        d0 = done_cnt; e0 = err_cnt; o0 = oe_cnt;
        preamble(31);
        read_frame(5'd1, 5'd2, got, ta2);
        n_tests++; if (oe_cnt - o0 !== 0 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL short_preamble got oe %0d done %0d err %0d want 0", oe_cnt - o0, done_cnt - d0, err_cnt - e0); end
        e0 = err_cnt;
        preamble(32); send(1'b0); send(1'b1); send(1'b1); send(1'b1);
        repeat (8) @(negedge clk_50);
        n_tests++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL bad_op_err got %0d want 1", err_cnt - e0); end
        e0 = err_cnt;
        preamble(32); send(1'b0); send(1'b0);
        repeat (8) @(negedge clk_50);
        n_tests++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL bad_st_err got %0d want 1", err_cnt - e0); end
        preamble(32); write_frame(5'd17, 16'h5A5A, 2'b10);
        d0 = done_cnt; e0 = err_cnt;
        preamble(32); write_frame(5'd17, 16'hFFFF, 2'b11);
        n_tests++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin n_fail++; $display("FAIL bad_ta got err %0d done %0d want 1/0", err_cnt - e0, done_cnt - d0); end
        exp_q.push_back(16'h5A5A); preamble(32); read_frame(5'd1, 5'd17, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL bad_ta_no_write got %h want %h", got, e); end
    endtask

    task automatic test_idle_high();
        logic [15:0] got, e;
        logic ta2;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        preamble(100);
        n_tests++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL idle_spurious got %0d/%0d want 0/0", done_cnt - d0, err_cnt - e0); end
        exp_q.push_back(16'h1556); read_frame(5'd1, 5'd3, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL read_after_idle got %h want %h", got, e); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] got, e;
        logic ta2, s;
        preamble(32); write_frame(5'd0, 16'h4000, 2'b10);
        preamble(32);
        send_hdr(2'b10, 5'd1, 5'd0);
        clk_bit(1'b0, 1'b1, s); clk_bit(1'b0, 1'b1, s);
        for (int i = 0; i < 8; i++) clk_bit(1'b0, 1'b1, s);
        n_tests++; if (oe_mdio !== 1'b1) begin n_fail++; $display("FAIL midframe_driving got %b want 1", oe_mdio); end
        rstn = 1'b0;
        #1;
        n_tests++; if (oe_mdio !== 1'b0) begin n_fail++; $display("FAIL midframe_reset_oe got %b want 0", oe_mdio); end
        n_tests++; if (o_bmcr !== 16'h3100) begin n_fail++; $display("FAIL midframe_reset_bmcr got %h want 3100", o_bmcr); end
        repeat (4) @(negedge clk_50);
        rstn = 1'b1;
        m_en = 1'b1; m_val = 1'b1;
        repeat (4) @(negedge clk_50);
        exp_q.push_back(16'h3100); preamble(32); read_frame(5'd1, 5'd0, got, ta2); e = exp_q.pop_front();
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL read_after_reset got %h want %h", got, e); end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_write_read();
        test_bmcr_reset();
        test_other_phy();
        test_bad_frames();
        test_idle_high();
        test_reset_midframe();
        n_tests++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL pulse_width got %0d wide pulses want 0", wide_cnt); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
